// File: rtl/cnu_pkg.sv
// Shared types and constants for the streaming min-sum check-node core.
// The min2_t tuple width is fixed here, so the top-level DATA_W / IDX_W
// parameters must keep their package defaults.
package cnu_pkg;

    localparam int CNU_DATA_W = 9;
    localparam int CNU_IDX_W  = 5;

    // Saturated magnitude, used for "no value yet" and for masked lanes
    localparam logic [CNU_DATA_W-1:0] MAG_MAX = '1;

    typedef struct packed {
        logic [CNU_DATA_W-1:0] m1;
        logic [CNU_DATA_W-1:0] m2;
        logic [CNU_IDX_W-1:0]  i1;
    } min2_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        OUT  = 2'd2
    } cnu_state_e;

    // Neutral tuple: merging it as the lower-index operand leaves the
    // other operand's values in place
    function automatic min2_t min2_init();
        min2_t t;
        t.m1 = MAG_MAX;
        t.m2 = MAG_MAX;
        t.i1 = '0;
        return t;
    endfunction

endpackage

// File: rtl/cnu_min2_merge.sv
// Combinational merge of two (min1, min2, idx1) tuples.
// Operand a always covers lower global indices than operand b, so a strict
// '<' keeps the lower index as min1 on ties and pushes the tied value to min2.
module cnu_min2_merge
    import cnu_pkg::*;
(
    input  min2_t a,
    input  min2_t b,
    output min2_t y
);

    // Select the overall minimum, then the runner-up from the two candidates
    always_comb begin
        y = a;
        if (b.m1 < a.m1) begin
            y.m1 = b.m1;
            y.i1 = b.i1;
            y.m2 = (a.m1 < b.m2) ? a.m1 : b.m2;
        end else begin
            y.m2 = (b.m1 < a.m2) ? b.m1 : a.m2;
        end
    end

endmodule

// File: rtl/cnu_min2_stream.sv
// Streaming min-sum check-node core: folds one parity-check row, LANES
// messages per beat, into min1 / min2 / index of min1 / XOR of signs.
module cnu_min2_stream
    import cnu_pkg::*;
#(
    parameter int DATA_W  = CNU_DATA_W,
    parameter int IDX_W   = CNU_IDX_W,
    parameter int LANES   = 4,
    parameter int MAX_DEG = 32,
    parameter int DEG_W   = $clog2(MAX_DEG + 1)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [LANES*DATA_W-1:0]   in_mag,
    input  logic [LANES-1:0]          in_sign,
    input  logic [DEG_W-1:0]          cfg_deg,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [DATA_W-1:0]         out_min1,
    output logic [DATA_W-1:0]         out_min2,
    output logic [IDX_W-1:0]          out_idx1,
    output logic                      out_sign
);

    localparam int MAX_BEATS = (MAX_DEG + LANES - 1) / LANES;
    localparam int BC_W      = (MAX_BEATS > 1) ? $clog2(MAX_BEATS + 1) : 1;

    cnu_state_e            state_q, state_d;
    logic [BC_W-1:0]       beat_cnt_q, beat_cnt_d;
    logic [DEG_W-1:0]      deg_q, deg_d;
    min2_t                 acc_q, acc_d;
    logic                  acc_sign_q, acc_sign_d;
    logic [DATA_W-1:0]     out_min1_q, out_min1_d;
    logic [DATA_W-1:0]     out_min2_q, out_min2_d;
    logic [IDX_W-1:0]      out_idx1_q, out_idx1_d;
    logic                  out_sign_q, out_sign_d;

    logic                  accept;
    logic [DEG_W-1:0]      cfg_clamped;
    logic [DEG_W-1:0]      deg_eff;
    int                    nbeats;
    logic                  last_beat;
    logic                  beat_sign;
    min2_t                 lane_t [LANES];
    min2_t                 chain  [LANES];
    min2_t                 acc_merged;

    assign accept = in_valid & in_ready;

    // Row degree in force for this beat: freshly clamped config on the first beat, latched value after
    always_comb begin
        cfg_clamped = cfg_deg;
        if (cfg_deg == '0) begin
            cfg_clamped = DEG_W'(1);
        end else if (int'(cfg_deg) > MAX_DEG) begin
            cfg_clamped = DEG_W'(MAX_DEG);
        end
        deg_eff   = (state_q == IDLE) ? cfg_clamped : deg_q;
        nbeats    = (int'(deg_eff) + LANES - 1) / LANES;
        last_beat = (int'(beat_cnt_q) == nbeats - 1);
    end

    // Build one tuple per lane; lanes past the row degree become saturated and sign-neutral
    always_comb begin
        beat_sign = 1'b0;
        for (int k = 0; k < LANES; k++) begin
            lane_t[k].m2 = MAG_MAX;
            lane_t[k].i1 = IDX_W'(int'(beat_cnt_q) * LANES + k);
            if (int'(beat_cnt_q) * LANES + k < int'(deg_eff)) begin
                lane_t[k].m1 = in_mag[k*DATA_W +: DATA_W];
                beat_sign    = beat_sign ^ in_sign[k];
            end else begin
                lane_t[k].m1 = MAG_MAX;
            end
        end
    end

    // Lanes are folded lowest index first so every merge sees the lower indices on its a side
    assign chain[0] = lane_t[0];

    for (genvar k = 1; k < LANES; k++) begin : g_tree
        cnu_min2_merge u_lane_merge (
            .a (chain[k-1]),
            .b (lane_t[k]),
            .y (chain[k])
        );
    end

    cnu_min2_merge u_acc_merge (
        .a (acc_q),
        .b (chain[LANES-1]),
        .y (acc_merged)
    );

    // Row sequencing: IDLE takes the first beat, ACC the rest, OUT holds the result
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = last_beat ? OUT : ACC;
            ACC:     if (accept && last_beat) state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Handshake outputs follow the state directly
    always_comb begin
        in_ready  = (state_q != OUT);
        out_valid = (state_q == OUT);
    end

    // Accumulate each accepted beat, capture the result on the last beat, re-arm after hand-off
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        deg_d      = deg_q;
        acc_d      = acc_q;
        acc_sign_d = acc_sign_q;
        out_min1_d = out_min1_q;
        out_min2_d = out_min2_q;
        out_idx1_d = out_idx1_q;
        out_sign_d = out_sign_q;
        if (accept) begin
            acc_d      = acc_merged;
            acc_sign_d = acc_sign_q ^ beat_sign;
            if (state_q == IDLE) begin
                deg_d = cfg_clamped;
            end
            if (last_beat) begin
                beat_cnt_d = '0;
                out_min1_d = acc_merged.m1;
                out_min2_d = acc_merged.m2;
                out_idx1_d = acc_merged.i1;
                out_sign_d = acc_sign_q ^ beat_sign;
            end else begin
                beat_cnt_d = beat_cnt_q + BC_W'(1);
            end
        end
        if ((state_q == OUT) && out_ready) begin
            acc_d      = min2_init();
            acc_sign_d = 1'b0;
            beat_cnt_d = '0;
        end
    end

    // State and datapath registers; reset discards any partial row
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            beat_cnt_q <= '0;
            deg_q      <= '0;
            acc_q      <= min2_init();
            acc_sign_q <= 1'b0;
            out_min1_q <= '0;
            out_min2_q <= '0;
            out_idx1_q <= '0;
            out_sign_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            beat_cnt_q <= beat_cnt_d;
            deg_q      <= deg_d;
            acc_q      <= acc_d;
            acc_sign_q <= acc_sign_d;
            out_min1_q <= out_min1_d;
            out_min2_q <= out_min2_d;
            out_idx1_q <= out_idx1_d;
            out_sign_q <= out_sign_d;
        end
    end

    assign out_min1 = out_min1_q;
    assign out_min2 = out_min2_q;
    assign out_idx1 = out_idx1_q;
    assign out_sign = out_sign_q;

endmodule
